// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the iterative AES key schedule:
//     - mode encodings latched from the key-load interface
//     - Nk / Nr / Nw lookup helpers (key words, rounds, schedule words)
//     - FSM state type and state constants
//     - xtime, used to step the round constant
//   No ports; imported by key_expansion_seq.
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam logic [1:0] MODE_128 = 2'b00;
  localparam logic [1:0] MODE_192 = 2'b01;
  localparam logic [1:0] MODE_256 = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t LOAD   = 2'd1;
  localparam state_t EXPAND = 2'd2;

  // Number of 32-bit words in the cipher key.
  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      MODE_128: nk_of = 4'd4;
      MODE_192: nk_of = 4'd6;
      default:  nk_of = 4'd8;
    endcase
  endfunction

  // Number of rounds; round keys 0..Nr are served.
  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      MODE_128: nr_of = 4'd10;
      MODE_192: nr_of = 4'd12;
      default:  nr_of = 4'd14;
    endcase
  endfunction

  // Total number of schedule words, 4*(Nr+1).
  function automatic logic [5:0] nw_of(input logic [1:0] m);
    case (m)
      MODE_128: nw_of = 6'd44;
      MODE_192: nw_of = 6'd52;
      default:  nw_of = 6'd60;
    endcase
  endfunction

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
//   Combinational forward AES S-box, one byte wide. Four copies form SubWord
//   inside the key schedule.
//   Ports:
//     din   in  8  input byte
//     dout  out 8  substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Row-major table: entry 0 is the first byte listed.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Pure table lookup; the byte value is the table index.
  assign dout = SBOX[din];

endmodule

// File: rtl/key_expansion_seq.sv
// ---------------------------------------------------------------------------
// key_expansion_seq
//   Iterative AES key schedule for 128/192/256-bit keys. After an accepted
//   start the Nk key words are written in one LOAD cycle, then one schedule
//   word per cycle is produced until w[Nw-1] is stored. Round keys are read
//   back through a registered port in forward or reverse round order.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start, mode, key    expansion request; key is LSB-aligned per mode
//     busy                high in LOAD and EXPAND
//     done                one-cycle pulse when the schedule is complete
//     keys_ready          store holds a complete schedule for mode_q
//     err                 one-cycle pulse on start with the illegal mode
//     rk_rd_en, rk_idx    round-key read request and round index
//     rk_reverse          read round Nr-rk_idx instead of rk_idx
//     rk_valid, rk_data   registered read result, w[4r] in the MSBs
// ---------------------------------------------------------------------------
module key_expansion_seq
  import aes_pkg::*;
#(
  parameter int MAX_KEY_W = 256,
  parameter int RK_W      = 128,
  parameter int MAX_WORDS = 60,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [MAX_KEY_W-1:0] key,
  output logic                 busy,
  output logic                 done,
  output logic                 keys_ready,
  output logic                 err,
  input  logic                 rk_rd_en,
  input  logic [IDX_W-1:0]     rk_idx,
  input  logic                 rk_reverse,
  output logic                 rk_valid,
  output logic [RK_W-1:0]      rk_data
);

  localparam int AW = IDX_W + 2;

  state_t                state;
  logic [1:0]            mode_q;
  logic [MAX_KEY_W-1:0]  key_q;
  logic [5:0]            wi;
  logic [2:0]            kpos;
  logic [7:0]            rcon;

  logic [31:0]           w [MAX_WORDS];

  logic [3:0]            nk;
  logic [IDX_W-1:0]      nr;
  logic [5:0]            nw;
  logic [31:0]           temp;
  logic [31:0]           wback;
  logic [31:0]           sub_in;
  logic [31:0]           sub_out;
  logic [31:0]           mixed;
  logic [31:0]           new_word;
  logic                  group_first;
  logic                  group_mid;
  logic [IDX_W-1:0]      eff_r;
  logic [AW-1:0]         rd_base;
  logic                  rd_ok;

  assign nk   = nk_of(mode_q);
  assign nr   = IDX_W'(nr_of(mode_q));
  assign nw   = nw_of(mode_q);
  assign busy = (state == LOAD) || (state == EXPAND);

  // kpos tracks i mod Nk so no divider is needed for the 192-bit case.
  // Position 0 gets RotWord+SubWord+rcon; for 256-bit keys position 4 gets
  // a bare SubWord.
  assign group_first = (kpos == 3'd0);
  assign group_mid   = (nk == 4'd8) && (kpos == 3'd4);
  assign temp        = w[wi - 6'd1];
  assign wback       = w[wi - {2'b00, nk}];
  assign sub_in      = group_first ? {temp[23:0], temp[31:24]} : temp;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .din  (sub_in[8*b +: 8]),
      .dout (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    mixed = temp;
    if (group_first) begin
      mixed = sub_out ^ {rcon, 24'h000000};
    end else if (group_mid) begin
      mixed = sub_out;
    end
    new_word = wback ^ mixed;
  end

  // Control FSM. The key is left-justified at latch time so that word 0 of
  // every key size sits in the top 32 bits, which keeps LOAD uniform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= MODE_128;
      key_q      <= '0;
      wi         <= '0;
      kpos       <= '0;
      rcon       <= 8'h01;
      done       <= 1'b0;
      err        <= 1'b0;
      keys_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mode == MODE_ILL) begin
              err <= 1'b1;
            end else begin
              state      <= LOAD;
              keys_ready <= 1'b0;
              mode_q     <= mode;
              key_q      <= key << (MAX_KEY_W - 32 * int'(nk_of(mode)));
              rcon       <= 8'h01;
            end
          end
        end
        LOAD: begin
          wi    <= {2'b00, nk};
          kpos  <= 3'd0;
          state <= EXPAND;
        end
        EXPAND: begin
          if (group_first) begin
            rcon <= xtime(rcon);
          end
          kpos <= ({1'b0, kpos} == nk - 4'd1) ? 3'd0 : kpos + 3'd1;
          wi   <= wi + 6'd1;
          if (wi == nw - 6'd1) begin
            state      <= IDLE;
            done       <= 1'b1;
            keys_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word store. Contents are don't-care until keys_ready, so no reset.
  // LOAD writes the Nk key words at once; EXPAND writes one word at w[wi].
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int j = 0; j < 8; j++) begin
        if (j < int'(nk)) begin
          w[j] <= key_q[MAX_KEY_W - 1 - 32 * j -: 32];
        end
      end
    end else if (state == EXPAND) begin
      w[wi] <= new_word;
    end
  end

  // Read address: the legality test is on the requested index, so a
  // reverse read of an out-of-range index is rejected before subtraction.
  assign eff_r   = rk_reverse ? (nr - rk_idx) : rk_idx;
  assign rd_base = {eff_r, 2'b00};
  assign rd_ok   = rk_rd_en && keys_ready && (rk_idx <= nr);

  // Registered read port. Any cycle without a legal read drives zeros so
  // stale round keys never linger on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_valid <= 1'b0;
      rk_data  <= '0;
    end else if (rd_ok) begin
      rk_valid <= 1'b1;
      rk_data  <= {w[rd_base], w[rd_base + AW'(1)],
                   w[rd_base + AW'(2)], w[rd_base + AW'(3)]};
    end else begin
      rk_valid <= 1'b0;
      rk_data  <= '0;
    end
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// ---------------------------------------------------------------------------
// tb_key_expansion_seq
//   Directed bench for key_expansion_seq using published AES key schedule
//   vectors for all three key sizes, plus the error, ignored-start and
//   mid-expansion reset cases.
// ---------------------------------------------------------------------------
module tb_key_expansion_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         keys_ready;
  logic         err;
  logic         rk_rd_en;
  logic [3:0]   rk_idx;
  logic         rk_reverse;
  logic         rk_valid;
  logic [127:0] rk_data;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] KEY128_FIPS = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY128_SEQ  = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY192_SEQ  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] KEY256_SEQ  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK0_SEQ     = 128'h000102030405060708090a0b0c0d0e0f;

  key_expansion_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .keys_ready (keys_ready),
    .err        (err),
    .rk_rd_en   (rk_rd_en),
    .rk_idx     (rk_idx),
    .rk_reverse (rk_reverse),
    .rk_valid   (rk_valid),
    .rk_data    (rk_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start; returns #1 after the edge that samples it.
  task automatic applyStimulus(input logic [1:0] m, input logic [255:0] k);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    key   = k;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges from the accepted start until done is seen high.
  task automatic waitDone(input string tag, input int expCycles, input int elapsed);
    int  cnt;
    bit  seen;
    cnt  = elapsed;
    seen = 1'b0;
    while (!seen && cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
      if (done) seen = 1'b1;
    end
    checkOutput({tag, " latency"}, 128'(cnt), 128'(expCycles));
    if (seen) begin
      checkOutput({tag, " keys_ready at done"}, 128'(keys_ready), 128'(1));
      checkOutput({tag, " err with done"}, 128'(err), 128'(0));
      checkOutput({tag, " busy at done"}, 128'(busy), 128'(0));
      @(posedge clk);
      #1;
      checkOutput({tag, " done pulse width"}, 128'(done), 128'(0));
    end
  endtask

  // One registered read; both valid and data are checked a cycle later.
  task automatic readRound(input string tag, input logic [3:0] idx, input logic rev,
                           input logic expValid, input logic [127:0] expData);
    @(negedge clk);
    rk_rd_en   = 1'b1;
    rk_idx     = idx;
    rk_reverse = rev;
    @(posedge clk);
    #1;
    rk_rd_en = 1'b0;
    checkOutput({tag, " valid"}, 128'(rk_valid), 128'(expValid));
    checkOutput({tag, " data"}, rk_data, expData);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    mode       = 2'b00;
    key        = '0;
    rk_rd_en   = 1'b0;
    rk_idx     = '0;
    rk_reverse = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 128'(busy), 128'(0));
    checkOutput("reset done", 128'(done), 128'(0));
    checkOutput("reset keys_ready", 128'(keys_ready), 128'(0));
    checkOutput("reset err", 128'(err), 128'(0));
    checkOutput("reset rk_valid", 128'(rk_valid), 128'(0));
    checkOutput("reset rk_data", rk_data, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] AES-128 FIPS-197 key");
    applyStimulus(2'b00, KEY128_FIPS);
    checkOutput("aes128 busy after start", 128'(busy), 128'(1));
    waitDone("aes128", 41, 0);
    readRound("aes128 r10", 4'd10, 1'b0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    readRound("aes128 r0", 4'd0, 1'b0, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(posedge clk);
    #1;
    checkOutput("no read valid", 128'(rk_valid), 128'(0));
    checkOutput("no read data", rk_data, 128'(0));

    $display("[TB] AES-128 sequential key, start pulsed while busy");
    applyStimulus(2'b00, KEY128_SEQ);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b10;
    key   = KEY256_SEQ;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("aes128 busy restart", 41, 5);
    readRound("aes128 seq r10", 4'd10, 1'b0, 1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    readRound("aes128 seq rev0", 4'd0, 1'b1, 1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    readRound("aes128 seq rev11", 4'd11, 1'b1, 1'b0, 128'h0);

    $display("[TB] AES-192 sequential key");
    applyStimulus(2'b01, KEY192_SEQ);
    readRound("aes192 read while busy", 4'd5, 1'b0, 1'b0, 128'h0);
    waitDone("aes192", 47, 1);
    readRound("aes192 r12", 4'd12, 1'b0, 1'b1, 128'ha4970a331a78dc09c418c271e3a41d5d);
    readRound("aes192 r13", 4'd13, 1'b0, 1'b0, 128'h0);
    readRound("aes192 rev12", 4'd12, 1'b1, 1'b1, RK0_SEQ);

    $display("[TB] AES-256 sequential key");
    applyStimulus(2'b10, KEY256_SEQ);
    waitDone("aes256", 53, 0);
    readRound("aes256 r14", 4'd14, 1'b0, 1'b1, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    readRound("aes256 r0", 4'd0, 1'b0, 1'b1, RK0_SEQ);

    $display("[TB] illegal mode start");
    applyStimulus(2'b11, KEY128_FIPS);
    checkOutput("illegal err pulse", 128'(err), 128'(1));
    checkOutput("illegal busy", 128'(busy), 128'(0));
    checkOutput("illegal done", 128'(done), 128'(0));
    @(posedge clk);
    #1;
    checkOutput("illegal err cleared", 128'(err), 128'(0));
    checkOutput("illegal keys_ready kept", 128'(keys_ready), 128'(1));
    readRound("illegal prior keys", 4'd14, 1'b0, 1'b1, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    $display("[TB] reset during expansion");
    applyStimulus(2'b00, KEY128_FIPS);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 128'(busy), 128'(0));
    checkOutput("abort done", 128'(done), 128'(0));
    checkOutput("abort keys_ready", 128'(keys_ready), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    readRound("abort read", 4'd0, 1'b0, 1'b0, 128'h0);
    applyStimulus(2'b00, KEY128_SEQ);
    waitDone("after abort", 41, 0);
    readRound("after abort r10", 4'd10, 1'b0, 1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
